// File: rtl/rv_regfile_pkg.sv
// Shared definitions for the callee-saved register save/restore sequencer:
// slot table, slot stride, FSM encoding and the next-enabled-slot search.
package rv_regfile_pkg;

  localparam int NSLOTS      = 11;
  localparam int SLOT_SHIFT  = 2;
  localparam int SLOT_STRIDE = 1 << SLOT_SHIFT;

  localparam logic [NSLOTS-1:0] ALL_SLOTS = '1;

  // Slot 0 sits in the low 5 bits: slot 0 -> x9, slots 1..10 -> x18..x27.
  localparam logic [NSLOTS*5-1:0] SLOT_REG_TABLE = {
    5'd27, 5'd26, 5'd25, 5'd24, 5'd23,
    5'd22, 5'd21, 5'd20, 5'd19, 5'd18,
    5'd9
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S_RD   = 3'd1,
    ST_S_WR   = 3'd2,
    ST_R_REQ  = 3'd3,
    ST_R_WAIT = 3'd4,
    ST_R_WB   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } slot_search_t;

  // Lowest enabled slot at or above 'from'; found = 0 when none remain.
  function automatic slot_search_t find_slot(input logic [NSLOTS-1:0] mask,
                                             input logic [3:0]        from);
    slot_search_t res;
    res = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && mask[i]) begin
        res.found = 1'b1;
        res.idx   = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_slot_map.sv
// Combinational slot number to register index lookup; unused slot codes map to x0.
module rf_slot_map
  import rv_regfile_pkg::*;
(
  input  logic [3:0] i_slot,
  output logic [4:0] o_reg
);

  always_comb begin
    o_reg = 5'd0;
    if (i_slot < 4'(NSLOTS)) begin
      o_reg = SLOT_REG_TABLE[int'(i_slot)*5 +: 5];
    end
  end

endmodule

// File: rtl/rf_save_restore_ctrl.sv
// Save/restore sequencer for the callee-saved set {x9, x18..x27}.
// Define RF_SLOT_MASK_EN to add the i_slot_mask port for per-slot enables.
module rf_save_restore_ctrl
  import rv_regfile_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int NSLOTS = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [AW-1:0]     i_base_addr,
`ifdef RF_SLOT_MASK_EN
  input  logic [NSLOTS-1:0] i_slot_mask,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [4:0]        o_readreg,
  input  logic [DW-1:0]     i_readout,
  output logic              o_rf_we,
  output logic [4:0]        o_rf_waddr,
  output logic [DW-1:0]     o_rf_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [AW-1:0]     o_mem_addr,
  output logic [DW-1:0]     o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [DW-1:0]     i_mem_rdata
);

  state_t            r_state, w_stateNext;
  logic [3:0]        r_slot, w_slotNext;
  logic [AW-1:2]     r_baseHi, w_baseHi;
  logic [4:0]        r_readreg, w_slotReg;
  logic [AW-1:0]     r_memAddr, w_addrNext;
  logic [DW-1:0]     r_memWdata, r_rdata;
  logic [NSLOTS-1:0] w_mask, w_maskStart;
  logic              w_capture, w_loadAddr;
  slot_search_t      w_first, w_next;
  logic              w_unused;

`ifdef RF_SLOT_MASK_EN
  logic [NSLOTS-1:0] r_mask;
  assign w_maskStart = i_slot_mask;
  assign w_mask      = r_mask;
`else
  assign w_maskStart = ALL_SLOTS;
  assign w_mask      = ALL_SLOTS;
`endif

  // Slot addresses are word aligned, so the two low base bits never matter.
  assign w_unused   = ^i_base_addr[1:0];
  assign w_first    = find_slot(w_maskStart, 4'd0);
  assign w_next     = find_slot(w_mask, r_slot + 4'd1);
  assign w_baseHi   = (r_state == ST_IDLE) ? i_base_addr[AW-1:2] : r_baseHi;
  assign w_addrNext = {w_baseHi, 2'b00} + AW'(w_slotNext) * AW'(SLOT_STRIDE);

  rf_slot_map u_slotMap (
    .i_slot (r_slot),
    .o_reg  (w_slotReg)
  );

  always_comb begin
    w_stateNext = r_state;
    w_slotNext  = r_slot;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (!w_first.found) begin
            w_stateNext = ST_DONE;
          end else begin
            w_slotNext  = w_first.idx;
            w_stateNext = i_mode ? ST_R_REQ : ST_S_RD;
          end
        end
      end
      ST_S_RD: w_stateNext = ST_S_WR;
      ST_S_WR: begin
        if (i_mem_ready) begin
          if (w_next.found) begin
            w_slotNext  = w_next.idx;
            w_stateNext = ST_S_RD;
          end else begin
            w_stateNext = ST_DONE;
          end
        end
      end
      ST_R_REQ: begin
        if (i_mem_ready) begin
          w_capture   = i_mem_rvalid;
          w_stateNext = i_mem_rvalid ? ST_R_WB : ST_R_WAIT;
        end
      end
      ST_R_WAIT: begin
        if (i_mem_rvalid) begin
          w_capture   = 1'b1;
          w_stateNext = ST_R_WB;
        end
      end
      ST_R_WB: begin
        if (w_next.found) begin
          w_slotNext  = w_next.idx;
          w_stateNext = ST_R_REQ;
        end else begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        w_slotNext  = 4'd0;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_slotNext  = 4'd0;
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Address is loaded once per slot on entry to the issuing state and held while waiting.
  assign w_loadAddr = ((w_stateNext == ST_S_RD) || (w_stateNext == ST_R_REQ)) &&
                      (w_stateNext != r_state);

  // Requests and write-backs are suppressed during the reset cycle itself.
  always_comb begin
    o_busy      = (r_state != ST_IDLE);
    o_done      = (r_state == ST_DONE);
    o_mem_req   = ((r_state == ST_S_WR) || (r_state == ST_R_REQ)) && !i_rst;
    o_mem_we    = (r_state == ST_S_WR);
    o_rf_we     = (r_state == ST_R_WB) && !i_rst;
    o_rf_waddr  = 5'd0;
    if (o_rf_we) begin
      o_rf_waddr = w_slotReg;
    end
    o_rf_wdata  = r_rdata;
    o_readreg   = (r_state == ST_S_RD) ? w_slotReg : r_readreg;
    o_mem_addr  = r_memAddr;
    o_mem_wdata = r_memWdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_slot     <= 4'd0;
      r_baseHi   <= '0;
      r_readreg  <= 5'd0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_rdata    <= '0;
`ifdef RF_SLOT_MASK_EN
      r_mask     <= '0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_slot  <= w_slotNext;
      if ((r_state == ST_IDLE) && i_start) begin
        r_baseHi <= i_base_addr[AW-1:2];
`ifdef RF_SLOT_MASK_EN
        r_mask   <= i_slot_mask;
`endif
      end
      if (w_loadAddr) begin
        r_memAddr <= w_addrNext;
      end
      if (r_state == ST_S_RD) begin
        r_memWdata <= i_readout;
        r_readreg  <= w_slotReg;
      end
      if (w_capture) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

endmodule
